// File: rtl/flipflop_jk_bank_pkg.sv
// Shared mode codes and JK cell function encoding for the JK register bank.
// Purely declarative; no state, no latency, no flow control.
package flipflop_jk_pkg;

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_UP = 2'b01;
  localparam logic [1:0] MODE_DN = 2'b10;
  localparam logic [1:0] MODE_SH = 2'b11;

  // Encoding is {j,k}.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_fn_e;

  function automatic logic jk_next(input logic j, input logic k, input logic q);
    jk_fn_e fn;
    logic   nxt;
    fn  = jk_fn_e'({j, k});
    nxt = q;
    case (fn)
      JK_HOLD:   nxt = q;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/flipflop_jk_bank_if.sv
// Control/data bundle of the JK bank: master drives controls, slave returns state.
// No handshake; every signal is sampled or updated on the bank clock edge.
interface flipflop_jk_bank_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             sin;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QN;
  logic             tc;
  logic             sout;

  modport master (
    output en, mode, J, K, sin,
    input  Q, QN, tc, sout
  );

  modport slave (
    input  en, mode, J, K, sin,
    output Q, QN, tc, sout
  );
endinterface

// File: rtl/flipflop_jk_bank_jk_cell.sv
// Single JK flip-flop with clock enable and synchronous reset to rst_val.
// One-cycle latency; en=0 holds, no backpressure.
module jk_cell
  import flipflop_jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else if (en) begin
      q <= jk_next(j, k, q);
    end
  end

endmodule

// File: rtl/flipflop_jk_bank.sv
// WIDTH-bit JK bank reconfigured per cycle as JK storage, up/down counter or shift register.
// One-cycle latency to Q and tc; en=0 stalls the whole bank, no other backpressure.
module flipflop_jk_bank
  import flipflop_jk_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  flipflop_jk_bank_if.slave   bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic [WIDTH-1:0] shift_src;
  logic [WIDTH-1:0] j_eff;
  logic [WIDTH-1:0] k_eff;
  logic             tc_nxt;
  logic             tc_q;

  // Toggle chains: bit i flips when all lower bits are ones (up) or zeros (down).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign up_t[i] = &q[i-1:0];
    assign dn_t[i] = ~|q[i-1:0];
  end

  assign shift_src = {q[WIDTH-2:0], bus.sin};

  // J/K/sin only reach the cells in the modes that use them.
  always_comb begin
    j_eff  = '0;
    k_eff  = '0;
    tc_nxt = 1'b0;
    case (bus.mode)
      MODE_JK: begin
        j_eff = bus.J;
        k_eff = bus.K;
      end
      MODE_UP: begin
        j_eff  = up_t;
        k_eff  = up_t;
        tc_nxt = &q;
      end
      MODE_DN: begin
        j_eff  = dn_t;
        k_eff  = dn_t;
        tc_nxt = ~|q;
      end
      MODE_SH: begin
        j_eff = shift_src;
        k_eff = ~shift_src;
      end
      default: begin
        j_eff  = '0;
        k_eff  = '0;
        tc_nxt = 1'b0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VAL[i]),
      .en      (bus.en),
      .j       (j_eff[i]),
      .k       (k_eff[i]),
      .q       (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= bus.en & tc_nxt;
    end
  end

  assign bus.Q    = q;
  assign bus.QN   = ~q;
  assign bus.sout = q[WIDTH-1];
  assign bus.tc   = tc_q;

endmodule

// File: tb/tb_flipflop_jk_bank.sv
// Directed table-driven bench for flipflop_jk_bank (WIDTH=4, RESET_VAL=4'b1010).
module tb_flipflop_jk_bank;
  import flipflop_jk_pkg::*;

  localparam int               W  = 4;
  localparam logic [W-1:0]     RV = 4'b1010;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  flipflop_jk_bank_if #(.WIDTH(W)) bus ();

  flipflop_jk_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         sin;
    logic [W-1:0] q;
    logic         tc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic e, logic [1:0] m,
                              logic [W-1:0] j, logic [W-1:0] k, logic s,
                              logic [W-1:0] q, logic tc);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.mode = m;
    v.j = j; v.k = k; v.sin = s; v.q = q; v.tc = tc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic step(logic r, logic e, logic [1:0] m, logic [W-1:0] j,
                      logic [W-1:0] k, logic s);
    rst = r; bus.en = e; bus.mode = m; bus.J = j; bus.K = k; bus.sin = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(string name, logic [W-1:0] q, logic tc);
    logic [W-1:0] qn;
    qn = ~q;
    chk({name, ".Q"},    32'(bus.Q),    32'(q));
    chk({name, ".QN"},   32'(bus.QN),   32'(qn));
    chk({name, ".tc"},   32'(bus.tc),   32'(tc));
    chk({name, ".sout"}, 32'(bus.sout), 32'(q[W-1]));
  endtask

  initial begin
    total = 0; passed = 0;
    rst = 1'b1; bus.en = 1'b0; bus.mode = MODE_JK;
    bus.J = '0; bus.K = '0; bus.sin = 1'b0;

    // Reset beats count mode; en=0 holds.
    vecs.push_back(mk("rst0", 1, 1, MODE_UP, 4'h0, 4'h0, 0, 4'b1010, 0));
    vecs.push_back(mk("rst1", 1, 1, MODE_UP, 4'h0, 4'h0, 0, 4'b1010, 0));
    vecs.push_back(mk("hold0", 0, 0, MODE_UP, 4'hF, 4'h0, 1, 4'b1010, 0));
    vecs.push_back(mk("hold1", 0, 0, MODE_JK, 4'hF, 4'hF, 1, 4'b1010, 0));
    vecs.push_back(mk("hold2", 0, 0, MODE_SH, 4'h0, 4'hF, 1, 4'b1010, 0));
    // JK truth table.
    vecs.push_back(mk("jk_clr", 0, 1, MODE_JK, 4'b0000, 4'b1111, 0, 4'b0000, 0));
    vecs.push_back(mk("jk_set", 0, 1, MODE_JK, 4'b1111, 4'b0000, 0, 4'b1111, 0));
    vecs.push_back(mk("jk_tog", 0, 1, MODE_JK, 4'b0011, 4'b0011, 0, 4'b1100, 0));
    vecs.push_back(mk("jk_mix", 0, 1, MODE_JK, 4'b0101, 4'b1010, 0, 4'b0101, 0));
    vecs.push_back(mk("jk_hld", 0, 1, MODE_JK, 4'b0000, 4'b0000, 1, 4'b0101, 0));
    // Down count with enable gaps; J/K junk must be ignored.
    vecs.push_back(mk("dn_clr", 0, 1, MODE_JK, 4'b0000, 4'b1111, 0, 4'b0000, 0));
    vecs.push_back(mk("dn_wrap", 0, 1, MODE_DN, 4'b1111, 4'b0000, 1, 4'b1111, 1));
    vecs.push_back(mk("dn_e1", 0, 1, MODE_DN, 4'b0101, 4'b0101, 1, 4'b1110, 0));
    vecs.push_back(mk("dn_e0", 0, 0, MODE_DN, 4'b0000, 4'b0000, 0, 4'b1110, 0));
    vecs.push_back(mk("dn_e1b", 0, 1, MODE_DN, 4'b1111, 4'b1111, 0, 4'b1101, 0));
    // Shift register.
    vecs.push_back(mk("sh_clr", 0, 1, MODE_JK, 4'b0000, 4'b1111, 0, 4'b0000, 0));
    vecs.push_back(mk("sh1", 0, 1, MODE_SH, 4'b1111, 4'b0000, 1, 4'b0001, 0));
    vecs.push_back(mk("sh2", 0, 1, MODE_SH, 4'b0000, 4'b1111, 0, 4'b0010, 0));
    vecs.push_back(mk("sh3", 0, 1, MODE_SH, 4'b1010, 4'b0101, 1, 4'b0101, 0));
    vecs.push_back(mk("sh4", 0, 1, MODE_SH, 4'b0000, 4'b0000, 1, 4'b1011, 0));
    vecs.push_back(mk("sh5", 0, 1, MODE_SH, 4'b1111, 4'b1111, 0, 4'b0110, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].j, vecs[i].k, vecs[i].sin);
      chk_state(vecs[i].name, vecs[i].q, vecs[i].tc);
    end

    // Up count through a full wrap.
    step(0, 1, MODE_JK, 4'b0000, 4'b1111, 0);
    chk_state("up_clr", 4'b0000, 0);
    for (int n = 1; n <= 15; n++) begin
      step(0, 1, MODE_UP, 4'b0000, 4'b1111, 1);
      chk_state($sformatf("up%0d", n), 4'(n), 0);
    end
    step(0, 1, MODE_UP, 4'b1111, 4'b0000, 0);
    chk_state("up16", 4'b0000, 1);
    step(0, 1, MODE_UP, 4'b0000, 4'b0000, 0);
    chk_state("up17", 4'b0001, 0);

    // Mode switch keeps Q as the starting point; reset mid-count discards the count.
    for (int n = 2; n <= 6; n++) begin
      step(0, 1, MODE_UP, 4'b0000, 4'b0000, 0);
      chk_state($sformatf("ms_up%0d", n), 4'(n), 0);
    end
    step(0, 1, MODE_DN, 4'b0000, 4'b0000, 0);
    chk_state("ms_dn", 4'b0101, 0);
    step(1, 1, MODE_DN, 4'b0000, 4'b0000, 0);
    chk_state("ms_rst", RV, 0);
    step(0, 0, MODE_DN, 4'b0000, 4'b0000, 0);
    chk_state("ms_hold", RV, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
